// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and data memory (slave).
interface mem_stage_if #(
  parameter int unsigned ADDR_W = 15
) ();

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ready,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready,
    output mem_rvalid,
    output mem_rdata
  );

endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: issues word loads/stores to data memory, forwards ALU
// results, and builds the register-file writeback bundle. Stalls upstream while
// a memory transaction is outstanding.
module mem_stage #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned REG_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_load,
  input  logic             ex_store,
  input  logic [31:0]      ex_res,
  input  logic [31:0]      ex_wdata,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_wb_en,
  mem_stage_if.master      mem,
  output logic             wb_valid,
  output logic             wb_we,
  output logic [REG_W-1:0] wb_rd,
  output logic [31:0]      wb_data,
  output logic             misalign,
  output logic             mem_nstall
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e              state_q, state_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [REG_W-1:0]    rd_q, rd_d;
  logic                wb_en_q, wb_en_d;
  logic                wb_valid_q, wb_valid_d;
  logic                wb_we_q, wb_we_d;
  logic [REG_W-1:0]    wb_rd_q, wb_rd_d;
  logic [31:0]         wb_data_q, wb_data_d;
  logic                misalign_q, misalign_d;

  // Next-state and writeback decode; pulses default low, data fields hold.
  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_d        = rd_q;
    wb_en_d     = wb_en_q;
    wb_valid_d  = 1'b0;
    wb_we_d     = wb_we_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    misalign_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ex_valid) begin
          if (!(ex_load || ex_store)) begin
            wb_valid_d = 1'b1;
            wb_we_d    = ex_wb_en;
            wb_rd_d    = ex_rd;
            wb_data_d  = ex_res;
          end else if (ex_res[1:0] != 2'b00) begin
            misalign_d = 1'b1;
          end else begin
            // Load wins when both load and store are flagged.
            mem_we_d    = ex_store & ~ex_load;
            mem_addr_d  = ex_res[ADDR_W+1:2];
            mem_wdata_d = ex_wdata;
            rd_d        = ex_rd;
            wb_en_d     = ex_wb_en;
            state_d     = StReq;
          end
        end
      end
      StReq: begin
        if (mem.mem_ready) begin
          if (mem_we_q) begin
            state_d = StIdle;
          end else if (mem.mem_rvalid) begin
            wb_valid_d = 1'b1;
            wb_we_d    = wb_en_q;
            wb_rd_d    = rd_q;
            wb_data_d  = mem.mem_rdata;
            state_d    = StIdle;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (mem.mem_rvalid) begin
          wb_valid_d = 1'b1;
          wb_we_d    = wb_en_q;
          wb_rd_d    = rd_q;
          wb_data_d  = mem.mem_rdata;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_q        <= '0;
      wb_en_q     <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_q        <= rd_d;
      wb_en_q     <= wb_en_d;
      wb_valid_q  <= wb_valid_d;
      wb_we_q     <= wb_we_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      misalign_q  <= misalign_d;
    end
  end

  // Request is a pure function of state so reset drops it without a clock.
  assign mem.mem_req   = (state_q == StReq);
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign wb_valid      = wb_valid_q;
  assign wb_we         = wb_we_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign misalign      = misalign_q;
  assign mem_nstall    = (state_q == StIdle);

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios followed by randomized transactions
// checked against a transaction-level model of the stage.
module tb_mem_stage;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned REG_W  = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             ex_valid = 1'b0;
  logic             ex_load = 1'b0;
  logic             ex_store = 1'b0;
  logic [31:0]      ex_res = '0;
  logic [31:0]      ex_wdata = '0;
  logic [REG_W-1:0] ex_rd = '0;
  logic             ex_wb_en = 1'b0;
  logic             wb_valid;
  logic             wb_we;
  logic [REG_W-1:0] wb_rd;
  logic [31:0]      wb_data;
  logic             misalign;
  logic             mem_nstall;

  int unsigned passed = 0;
  int unsigned total  = 0;

  mem_stage_if #(.ADDR_W(ADDR_W)) mem_bus ();

  mem_stage #(.ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_load    (ex_load),
    .ex_store   (ex_store),
    .ex_res     (ex_res),
    .ex_wdata   (ex_wdata),
    .ex_rd      (ex_rd),
    .ex_wb_en   (ex_wb_en),
    .mem        (mem_bus),
    .wb_valid   (wb_valid),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .misalign   (misalign),
    .mem_nstall (mem_nstall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic st, input logic [31:0] res,
                       input logic [31:0] wd, input logic [REG_W-1:0] rd, input logic en);
    ex_valid = 1'b1;
    ex_load  = ld;
    ex_store = st;
    ex_res   = res;
    ex_wdata = wd;
    ex_rd    = rd;
    ex_wb_en = en;
  endtask

  task automatic idle_ex();
    ex_valid = 1'b0;
    ex_load  = 1'b0;
    ex_store = 1'b0;
  endtask

  // Word address the model expects for a byte address.
  function automatic logic [31:0] word_addr(input logic [31:0] res);
    return (res >> 2) % (32'd1 << ADDR_W);
  endfunction

  initial begin
    logic [31:0] last_data;
    logic [31:0] last_rd;
    logic [31:0] exp_a;

    mem_bus.mem_ready  = 1'b0;
    mem_bus.mem_rvalid = 1'b0;
    mem_bus.mem_rdata  = '0;

    // Reset values.
    #12;
    check("rst_req", mem_bus.mem_req, 0);
    check("rst_we", mem_bus.mem_we, 0);
    check("rst_addr", mem_bus.mem_addr, 0);
    check("rst_wdata", mem_bus.mem_wdata, 0);
    check("rst_wbv", wb_valid, 0);
    check("rst_wbwe", wb_we, 0);
    check("rst_wbrd", wb_rd, 0);
    check("rst_wbdata", wb_data, 0);
    check("rst_mis", misalign, 0);
    check("rst_nstall", mem_nstall, 1);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Three back-to-back ALU ops.
    for (int i = 1; i <= 3; i++) begin
      issue(1'b0, 1'b0, i, 32'h0, REG_W'(4 + i), 1'b1);
      check("alu_nstall_in", mem_nstall, 1);
      step();
      check("alu_wbv", wb_valid, 1);
      check("alu_wbwe", wb_we, 1);
      check("alu_rd", wb_rd, 4 + i);
      check("alu_data", wb_data, i);
      check("alu_req", mem_bus.mem_req, 0);
    end
    idle_ex();
    step();
    check("alu_end_wbv", wb_valid, 0);
    check("alu_hold_data", wb_data, 3);

    // lw 0x10, ready held low for three cycles.
    issue(1'b1, 1'b0, 32'h10, 32'h0, REG_W'(9), 1'b1);
    step();
    idle_ex();
    for (int i = 0; i < 4; i++) begin
      check("lw_req", mem_bus.mem_req, 1);
      check("lw_we", mem_bus.mem_we, 0);
      check("lw_addr", mem_bus.mem_addr, 4);
      check("lw_nstall", mem_nstall, 0);
      if (i < 3) step();
    end
    mem_bus.mem_ready = 1'b1;
    step();
    mem_bus.mem_ready = 1'b0;
    check("lw_wait_req", mem_bus.mem_req, 0);
    check("lw_wait_nstall", mem_nstall, 0);
    step();
    check("lw_wait2_wbv", wb_valid, 0);
    mem_bus.mem_rvalid = 1'b1;
    mem_bus.mem_rdata  = 32'hDEADBEEF;
    step();
    mem_bus.mem_rvalid = 1'b0;
    check("lw_wbv", wb_valid, 1);
    check("lw_data", wb_data, 32'hDEADBEEF);
    check("lw_rd", wb_rd, 9);
    check("lw_nstall_back", mem_nstall, 1);
    step();
    check("lw_pulse", wb_valid, 0);

    // sw 0x20 with immediate ready; stray rvalid in IDLE must be ignored.
    mem_bus.mem_ready  = 1'b1;
    mem_bus.mem_rvalid = 1'b1;
    issue(1'b0, 1'b1, 32'h20, 32'h1234, REG_W'(2), 1'b0);
    step();
    idle_ex();
    mem_bus.mem_rvalid = 1'b0;
    check("sw_req", mem_bus.mem_req, 1);
    check("sw_we", mem_bus.mem_we, 1);
    check("sw_addr", mem_bus.mem_addr, 8);
    check("sw_wdata", mem_bus.mem_wdata, 32'h1234);
    check("sw_wbv0", wb_valid, 0);
    step();
    mem_bus.mem_ready = 1'b0;
    check("sw_req_done", mem_bus.mem_req, 0);
    check("sw_wbv", wb_valid, 0);
    check("sw_nstall", mem_nstall, 1);
    check("sw_hold_data", wb_data, 32'hDEADBEEF);

    // flw with ready and rvalid in the first REQ cycle.
    mem_bus.mem_ready  = 1'b1;
    mem_bus.mem_rvalid = 1'b1;
    mem_bus.mem_rdata  = 32'h3F800000;
    issue(1'b1, 1'b0, 32'h40, 32'h0, 6'b100011, 1'b1);
    step();
    idle_ex();
    check("flw_wbv1", wb_valid, 0);
    check("flw_req", mem_bus.mem_req, 1);
    step();
    mem_bus.mem_ready  = 1'b0;
    mem_bus.mem_rvalid = 1'b0;
    check("flw_wbv2", wb_valid, 1);
    check("flw_rd", wb_rd, 35);
    check("flw_data", wb_data, 32'h3F800000);

    // Misaligned lw, then an ALU op accepted immediately.
    issue(1'b1, 1'b0, 32'h13, 32'h0, REG_W'(1), 1'b1);
    step();
    check("mis_pulse", misalign, 1);
    check("mis_req", mem_bus.mem_req, 0);
    check("mis_wbv", wb_valid, 0);
    check("mis_nstall", mem_nstall, 1);
    issue(1'b0, 1'b0, 32'h77, 32'h0, REG_W'(4), 1'b1);
    step();
    idle_ex();
    check("mis_clear", misalign, 0);
    check("mis_next_wbv", wb_valid, 1);
    check("mis_next_data", wb_data, 32'h77);
    last_data = 32'h77;
    last_rd   = 4;

    // Randomized transactions against the transaction-level model.
    for (int n = 0; n < 40; n++) begin
      int unsigned kind;
      logic [31:0] res;
      logic [31:0] wd;
      logic [31:0] rdat;
      logic [REG_W-1:0] rd;
      logic en;
      logic is_load;
      kind = $urandom_range(0, 3);  // 0 alu, 1 load, 2 store, 3 load+store
      res  = $urandom;
      wd   = $urandom;
      rdat = $urandom;
      rd   = REG_W'($urandom);
      en   = 1'($urandom);
      if (kind != 0) begin
        if ($urandom_range(0, 4) == 0) begin
          if (res[1:0] == 2'b00) res[0] = 1'b1;
        end else begin
          res[1:0] = 2'b00;
        end
      end
      is_load = (kind == 1) || (kind == 3);
      issue(kind == 1 || kind == 3, kind == 2 || kind == 3, res, wd, rd, en);
      step();
      idle_ex();
      if (kind == 0) begin
        check("r_alu_wbv", wb_valid, 1);
        check("r_alu_we", wb_we, en);
        check("r_alu_rd", wb_rd, rd);
        check("r_alu_data", wb_data, res);
        last_data = res;
        last_rd   = rd;
      end else if (res % 4 != 0) begin
        check("r_mis", misalign, 1);
        check("r_mis_req", mem_bus.mem_req, 0);
        check("r_mis_wbv", wb_valid, 0);
      end else begin
        exp_a = word_addr(res);
        repeat ($urandom_range(0, 3)) begin
          check("r_req_hold", mem_bus.mem_req, 1);
          check("r_addr_hold", mem_bus.mem_addr, exp_a);
          step();
        end
        check("r_req", mem_bus.mem_req, 1);
        check("r_we", mem_bus.mem_we, !is_load);
        check("r_addr", mem_bus.mem_addr, exp_a);
        check("r_wdata", mem_bus.mem_wdata, wd);
        check("r_nstall", mem_nstall, 0);
        mem_bus.mem_ready  = 1'b1;
        mem_bus.mem_rdata  = rdat;
        mem_bus.mem_rvalid = 1'($urandom);
        if (is_load && !mem_bus.mem_rvalid) begin
          step();
          mem_bus.mem_ready = 1'b0;
          check("r_wait_req", mem_bus.mem_req, 0);
          check("r_wait_nstall", mem_nstall, 0);
          repeat ($urandom_range(0, 3)) begin
            step();
            check("r_wait_wbv", wb_valid, 0);
          end
          mem_bus.mem_rvalid = 1'b1;
        end
        step();
        mem_bus.mem_ready  = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        if (is_load) begin
          check("r_ld_wbv", wb_valid, 1);
          check("r_ld_we", wb_we, en);
          check("r_ld_rd", wb_rd, rd);
          check("r_ld_data", wb_data, rdat);
          last_data = rdat;
          last_rd   = rd;
        end else begin
          check("r_st_wbv", wb_valid, 0);
          check("r_st_hold", wb_data, last_data);
          check("r_st_hold_rd", wb_rd, last_rd);
        end
        check("r_nstall_back", mem_nstall, 1);
      end
      step();
      check("r_idle_wbv", wb_valid, 0);
      check("r_idle_mis", misalign, 0);
    end

    // Reset asserted mid-WAIT aborts the load.
    issue(1'b1, 1'b0, 32'h100, 32'h0, REG_W'(12), 1'b1);
    step();
    idle_ex();
    mem_bus.mem_ready = 1'b1;
    step();
    mem_bus.mem_ready = 1'b0;
    check("rw_in_wait", mem_nstall, 0);
    #3;
    rst = 1'b0;
    #1;
    check("rw_req_async", mem_bus.mem_req, 0);
    check("rw_nstall_async", mem_nstall, 1);
    check("rw_wbv_async", wb_valid, 0);
    check("rw_data_async", wb_data, 0);
    step();
    rst = 1'b1;
    mem_bus.mem_rvalid = 1'b1;
    mem_bus.mem_rdata  = 32'hCAFEF00D;
    step();
    mem_bus.mem_rvalid = 1'b0;
    check("rw_late_wbv", wb_valid, 0);
    check("rw_late_data", wb_data, 0);
    check("rw_late_req", mem_bus.mem_req, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
